// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and helpers for the pipelined carry-lookahead adder.
// Latency: none (package only).
// Backpressure: not applicable.
package cla_pkg;

    // Width of one carry-lookahead group inside a segment.
    localparam int GROUP_W = 4;

    // Bits handled by one pipeline segment.
    function automatic int segw(input int width, input int stages);
        return width / stages;
    endfunction

    // A legal configuration splits evenly into whole lookahead groups per segment.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages > 0) && (width > 0) && ((width % (stages * GROUP_W)) == 0);
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result bundle for the pipelined carry-lookahead adder.
// Latency: none (wires only).
// Backpressure: valid/ready on both the operand and the result side.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_in;
    logic             SUB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             C_out;
    logic             OVF;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, A, B, C_in, SUB, out_ready,
        input  in_ready, out_valid, S, C_out, OVF
    );

    // The adder itself.
    modport slave (
        input  in_valid, A, B, C_in, SUB, out_ready,
        output in_ready, out_valid, S, C_out, OVF
    );
endinterface

// File: rtl/pipelined_cla_adder_segment.sv
// One combinational carry-lookahead slice: 4-bit groups, lookahead across groups.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline stage decides when results are captured.
module cla_segment
    import cla_pkg::*;
#(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout,
    output logic             msb_carry_in
);
    localparam int NG = SEG_W / GROUP_W;

    logic [SEG_W-1:0] p;
    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] c;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;

    // Bit propagate/generate, folded into group generate/propagate terms.
    always_comb begin
        logic acc_g;
        logic acc_p;
        acc_g = 1'b0;
        acc_p = 1'b1;
        p     = a ^ b;
        g     = a & b;
        gg    = '0;
        gp    = '0;
        for (int j = 0; j < NG; j++) begin
            acc_g = 1'b0;
            acc_p = 1'b1;
            for (int i = GROUP_W - 1; i >= 0; i--) begin
                acc_g = acc_g | (acc_p & g[j*GROUP_W + i]);
                acc_p = acc_p & p[j*GROUP_W + i];
            end
            gg[j] = acc_g;
            gp[j] = acc_p;
        end
    end

    // Group carry-ins as flat sum-of-products over lower groups and cin.
    always_comb begin
        logic acc_c;
        logic acc_p;
        acc_c = 1'b0;
        acc_p = 1'b1;
        gc    = '0;
        gc[0] = cin;
        for (int j = 0; j < NG; j++) begin
            acc_c = 1'b0;
            acc_p = 1'b1;
            for (int i = j; i >= 0; i--) begin
                acc_c = acc_c | (acc_p & gg[i]);
                acc_p = acc_p & gp[i];
            end
            gc[j+1] = acc_c | (acc_p & cin);
        end
    end

    // Per-bit carries, looked ahead only from their own group's carry-in.
    always_comb begin
        logic acc_c;
        logic acc_p;
        acc_c = 1'b0;
        acc_p = 1'b1;
        c     = '0;
        for (int j = 0; j < NG; j++) begin
            for (int m = 0; m < GROUP_W; m++) begin
                acc_c = 1'b0;
                acc_p = 1'b1;
                for (int i = m - 1; i >= 0; i--) begin
                    acc_c = acc_c | (acc_p & g[j*GROUP_W + i]);
                    acc_p = acc_p & p[j*GROUP_W + i];
                end
                c[j*GROUP_W + m] = acc_c | (acc_p & gc[j]);
            end
        end
    end

    assign s            = p ^ c;
    assign cout         = gc[NG];
    assign msb_carry_in = c[SEG_W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor; one SEG_W-bit segment resolved per stage.
// Latency: STAGES cycles (result visible after edge n+STAGES-1 for a beat taken at edge n).
// Backpressure: whole pipe advances only when the output is empty or taken; in_ready mirrors that.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int SEG_W = segw(WIDTH, STAGES);
    localparam int L     = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_cla_adder: WIDTH must be a multiple of STAGES*GROUP_W");
    end

    logic                adv;
    logic                take;
    logic [STAGES-1:0]   vld_q;
    logic [STAGES-1:0]   c_q;
    logic                ovf_q;
    logic [WIDTH-1:0]    a_q   [STAGES];
    logic [WIDTH-1:0]    b_q   [STAGES];
    logic [WIDTH-1:0]    s_q   [STAGES];

    logic [WIDTH-1:0]    a_src [STAGES];
    logic [WIDTH-1:0]    b_src [STAGES];
    logic [WIDTH-1:0]    s_src [STAGES];
    logic [STAGES-1:0]   c_src;
    logic [WIDTH-1:0]    s_nxt [STAGES];
    logic [SEG_W-1:0]    seg_s [STAGES];
    logic [STAGES-1:0]   seg_c;
    logic [STAGES-1:0]   seg_mc;
    logic                ovf_nxt;

    assign adv          = !vld_q[L] || bus.out_ready;
    assign take         = bus.in_valid && adv;
    assign bus.in_ready = adv;

    // Stage inputs: stage 0 sees the (possibly inverted) operands, later stages the skew registers.
    always_comb begin
        a_src[0] = bus.A;
        b_src[0] = bus.SUB ? ~bus.B : bus.B;
        c_src    = '0;
        c_src[0] = bus.SUB | bus.C_in;
        s_src[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            c_src[k] = c_q[k-1];
            s_src[k] = s_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        cla_segment #(
            .SEG_W        (SEG_W)
        ) u_seg (
            .a            (a_src[k][k*SEG_W +: SEG_W]),
            .b            (b_src[k][k*SEG_W +: SEG_W]),
            .cin          (c_src[k]),
            .s            (seg_s[k]),
            .cout         (seg_c[k]),
            .msb_carry_in (seg_mc[k])
        );
    end

    // Merge each stage's freshly computed slice into the partial sum it carries forward.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_nxt[k]                   = s_src[k];
            s_nxt[k][k*SEG_W +: SEG_W] = seg_s[k];
        end
    end

    // Signed overflow from the retained operand MSBs and the final-segment sum MSB.
    assign ovf_nxt = (a_src[L][WIDTH-1] == b_src[L][WIDTH-1]) &&
                     (seg_s[L][SEG_W-1] != a_src[L][WIDTH-1]);

    // Pipeline registers: clear on reset, shift together on adv, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q[0] <= take;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
                s_q[k] <= s_nxt[k];
                c_q[k] <= seg_c[k];
            end
            ovf_q <= ovf_nxt;
        end
    end

    assign bus.out_valid = vld_q[L];
    assign bus.S         = s_q[L];
    assign bus.C_out     = c_q[L];
    assign bus.OVF       = ovf_q;

endmodule
